// File: rtl/psr_flag_controller.sv
// psr_flag_controller
//
// Processor status register (PSR) with a shadow stack for interrupt entry/exit.
// Flags are {C,Z,L,F,N} with bit4=C and bit0=N.
//
// In IDLE, masked flag writes update the PSR.
// An interrupt entry pushes the PSR onto the shadow stack and clears it.
// An interrupt exit pops the top entry back into the PSR.
// Stack overflow and underflow set a sticky error flag.
//
// Optional feature: define PSR_COND_EVAL_EN to build the branch-condition
// decoder. Without it, cond_true is tied to 0 and cond_code is ignored.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   alu_flags     candidate flag values
//   flag_wr_mask  per-flag write enable
//   flag_wr_valid qualifies alu_flags/flag_wr_mask (IDLE only)
//   int_enter     level request: save PSR, then clear it
//   int_exit      level request: restore PSR from stack
//   req_ack       one-cycle pulse on completion of a save/restore
//   err_clr       clears stack_err
//   cond_code     branch condition selector
//   psr_out       current flags
//   cond_true     cond_code evaluated against psr_out (combinational)
//   busy          FSM not in IDLE
//   stack_empty   pointer == 0
//   stack_full    pointer == STACK_DEPTH
//   stack_err     sticky overflow/underflow flag

module psr_flag_controller #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] alu_flags,
    input  logic [4:0] flag_wr_mask,
    input  logic       flag_wr_valid,
    input  logic       int_enter,
    input  logic       int_exit,
    output logic       req_ack,
    input  logic       err_clr,
    input  logic [3:0] cond_code,
    output logic [4:0] psr_out,
    output logic       cond_true,
    output logic       busy,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err
);

    // The pointer must reach STACK_DEPTH itself, so it needs one more code than the index.
    localparam int unsigned PtrW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StSave, StRestore, StDone} state_e;

    state_e          state_q;
    logic [4:0]      psr_q;
    logic [PtrW-1:0] ptr_q;
    logic            err_q;
    logic            ack_q;
    logic [4:0]      stack_q [STACK_DEPTH];

    logic [PtrW-1:0] pop_ptr;
    logic [IdxW-1:0] push_idx;
    logic [IdxW-1:0] pop_idx;
    logic            err_set;

    assign stack_empty = (ptr_q == '0);
    assign stack_full  = (ptr_q == PtrW'(STACK_DEPTH));
    assign pop_ptr     = ptr_q - 1'b1;
    assign push_idx    = ptr_q[IdxW-1:0];
    assign pop_idx     = pop_ptr[IdxW-1:0];

    assign err_set = ((state_q == StSave) && stack_full) ||
                     ((state_q == StRestore) && stack_empty);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            psr_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The flag write lands in the same edge as the request, so SAVE
                    // pushes the merged value.
                    if (flag_wr_valid) begin
                        psr_q <= (psr_q & ~flag_wr_mask) | (alu_flags & flag_wr_mask);
                    end
                    if (int_enter) begin
                        state_q <= StSave;
                    end else if (int_exit) begin
                        state_q <= StRestore;
                    end
                end
                StSave: begin
                    if (!stack_full) begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                    psr_q   <= '0;
                    ack_q   <= 1'b1;
                    state_q <= StDone;
                end
                StRestore: begin
                    if (!stack_empty) begin
                        psr_q <= stack_q[pop_idx];
                        ptr_q <= pop_ptr;
                    end
                    ack_q   <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    // Wait for the requester to drop its level request.
                    if (!int_enter && !int_exit) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A same-cycle error set wins over a clear.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // Stack contents need no reset; the pointer alone defines validity.
    always_ff @(posedge clock) begin
        if ((state_q == StSave) && !stack_full) begin
            stack_q[push_idx] <= psr_q;
        end
    end

    assign psr_out   = psr_q;
    assign req_ack   = ack_q;
    assign stack_err = err_q;
    assign busy      = (state_q != StIdle);

`ifdef PSR_COND_EVAL_EN
    logic flag_c, flag_z, flag_l, flag_f, flag_n;

    assign flag_c = psr_q[4];
    assign flag_z = psr_q[3];
    assign flag_l = psr_q[2];
    assign flag_f = psr_q[1];
    assign flag_n = psr_q[0];

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_code)
            4'h0: cond_true = flag_z;
            4'h1: cond_true = !flag_z;
            4'h2: cond_true = flag_c;
            4'h3: cond_true = !flag_c;
            4'h4: cond_true = flag_l;
            4'h5: cond_true = !flag_l;
            4'h6: cond_true = flag_n;
            4'h7: cond_true = !flag_n;
            4'h8: cond_true = flag_f;
            4'h9: cond_true = !flag_f;
            4'hA: cond_true = !flag_l && !flag_z;
            4'hB: cond_true = flag_l || flag_z;
            4'hC: cond_true = !flag_n && !flag_z;
            4'hD: cond_true = flag_n || flag_z;
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end
`else
    logic unused_cond_code;

    assign unused_cond_code = ^cond_code;
    assign cond_true        = 1'b0;
`endif

endmodule

// File: tb/tb_psr_flag_controller.sv
module tb_psr_flag_controller;

    logic       clock;
    logic       reset;
    logic [4:0] alu_flags;
    logic [4:0] flag_wr_mask;
    logic       flag_wr_valid;
    logic       int_enter;
    logic       int_exit;
    logic       req_ack;
    logic       err_clr;
    logic [3:0] cond_code;
    logic [4:0] psr_out;
    logic       cond_true;
    logic       busy;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    int checks = 0;
    int errors = 0;

    psr_flag_controller #(
        .STACK_DEPTH(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .alu_flags    (alu_flags),
        .flag_wr_mask (flag_wr_mask),
        .flag_wr_valid(flag_wr_valid),
        .int_enter    (int_enter),
        .int_exit     (int_exit),
        .req_ack      (req_ack),
        .err_clr      (err_clr),
        .cond_code    (cond_code),
        .psr_out      (psr_out),
        .cond_true    (cond_true),
        .busy         (busy),
        .stack_empty  (stack_empty),
        .stack_full   (stack_full),
        .stack_err    (stack_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       valid;
        logic [4:0] mask;
        logic [4:0] alu;
        logic [4:0] exp_psr;
    } wr_vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_psr(input logic [4:0] value);
        flag_wr_valid = 1'b1;
        flag_wr_mask  = 5'b11111;
        alu_flags     = value;
        tick();
        flag_wr_valid = 1'b0;
    endtask

    // Issue a one-cycle request and leave the FSM in DONE.
    task automatic req_done(input logic enter, input logic exit_req);
        int_enter = enter;
        int_exit  = exit_req;
        tick();
        int_enter = 1'b0;
        int_exit  = 1'b0;
        tick();
    endtask

    task automatic cond_sweep(input logic [4:0] psr_val, input logic [15:0] truth);
        logic [15:0] tbl;
        logic        exp;
        tbl = truth;
        write_psr(psr_val);
        for (int c = 0; c < 16; c++) begin
            cond_code = 4'(c);
            #1;
`ifdef PSR_COND_EVAL_EN
            exp = tbl[c];
`else
            exp = 1'b0;
`endif
            check($sformatf("cond psr=%b code=%0h", psr_val, c), 16'(cond_true), 16'(exp));
        end
        cond_code = 4'h0;
    endtask

    wr_vec_t vecs [5];
    logic    ack_seen;

    initial begin
        vecs[0] = '{1'b1, 5'b10100, 5'b11111, 5'b10100};
        vecs[1] = '{1'b1, 5'b00011, 5'b00001, 5'b10101};
        vecs[2] = '{1'b0, 5'b11111, 5'b00000, 5'b10101};
        vecs[3] = '{1'b1, 5'b11111, 5'b01011, 5'b01011};
        vecs[4] = '{1'b1, 5'b00000, 5'b10000, 5'b01011};

        reset         = 1'b1;
        alu_flags     = '0;
        flag_wr_mask  = '0;
        flag_wr_valid = 1'b0;
        int_enter     = 1'b0;
        int_exit      = 1'b0;
        err_clr       = 1'b0;
        cond_code     = '0;

        #2 reset = 1'b0;
        #1;
        check("reset psr_out", 16'(psr_out), 16'h0);
        check("reset busy", 16'(busy), 16'h0);
        check("reset stack_empty", 16'(stack_empty), 16'h1);
        check("reset stack_full", 16'(stack_full), 16'h0);
        check("reset stack_err", 16'(stack_err), 16'h0);
        check("reset req_ack", 16'(req_ack), 16'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Masked writes from the vector table.
        for (int i = 0; i < 5; i++) begin
            flag_wr_valid = vecs[i].valid;
            flag_wr_mask  = vecs[i].mask;
            alu_flags     = vecs[i].alu;
            tick();
            check($sformatf("write vec %0d psr_out", i), 16'(psr_out), 16'(vecs[i].exp_psr));
        end
        flag_wr_valid = 1'b0;

        // Save/restore round trip, with flag writes dropped while busy.
        int_enter = 1'b1;
        tick();
        check("save state busy", 16'(busy), 16'h1);
        check("save state req_ack", 16'(req_ack), 16'h0);
        flag_wr_valid = 1'b1;
        flag_wr_mask  = 5'b11111;
        alu_flags     = 5'b11111;
        tick();
        check("save done req_ack", 16'(req_ack), 16'h1);
        check("save done psr_out", 16'(psr_out), 16'h00);
        check("save done stack_empty", 16'(stack_empty), 16'h0);
        tick();
        check("done held req_ack", 16'(req_ack), 16'h0);
        check("done held busy", 16'(busy), 16'h1);
        check("busy write dropped", 16'(psr_out), 16'h00);
        int_enter     = 1'b0;
        flag_wr_valid = 1'b0;
        tick();
        check("back to idle busy", 16'(busy), 16'h0);
        int_exit = 1'b1;
        tick();
        int_exit = 1'b0;
        tick();
        check("restore psr_out", 16'(psr_out), 16'h0B);
        check("restore stack_empty", 16'(stack_empty), 16'h1);
        check("restore req_ack", 16'(req_ack), 16'h1);
        tick();

        // Underflow; the error set beats a concurrent clear.
        err_clr = 1'b1;
        req_done(1'b0, 1'b1);
        check("underflow stack_err", 16'(stack_err), 16'h1);
        check("underflow psr_out", 16'(psr_out), 16'h0B);
        check("underflow req_ack", 16'(req_ack), 16'h1);
        tick();
        check("underflow err_clr", 16'(stack_err), 16'h0);
        err_clr = 1'b0;

        // Fill the stack, then overflow it.
        for (int i = 0; i < 4; i++) begin
            write_psr(5'(i + 1));
            req_done(1'b1, 1'b0);
            tick();
        end
        check("fill stack_full", 16'(stack_full), 16'h1);
        check("fill stack_err", 16'(stack_err), 16'h0);
        write_psr(5'd5);
        req_done(1'b1, 1'b0);
        check("overflow stack_err", 16'(stack_err), 16'h1);
        check("overflow stack_full", 16'(stack_full), 16'h1);
        check("overflow req_ack", 16'(req_ack), 16'h1);
        check("overflow psr_out", 16'(psr_out), 16'h00);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("overflow err_clr", 16'(stack_err), 16'h0);
        for (int i = 0; i < 4; i++) begin
            req_done(1'b0, 1'b1);
            check($sformatf("lifo pop %0d", i), 16'(psr_out), 16'(4 - i));
            tick();
        end
        check("drained stack_empty", 16'(stack_empty), 16'h1);

        // Flag write in the same cycle as the save request.
        write_psr(5'b00000);
        flag_wr_valid = 1'b1;
        flag_wr_mask  = 5'b00001;
        alu_flags     = 5'b00001;
        int_enter     = 1'b1;
        tick();
        flag_wr_valid = 1'b0;
        int_enter     = 1'b0;
        check("merged before save", 16'(psr_out), 16'h01);
        tick();
        check("merged after save", 16'(psr_out), 16'h00);
        tick();
        req_done(1'b0, 1'b1);
        check("merged entry popped", 16'(psr_out), 16'h01);
        tick();

        // Condition decoder.
        cond_sweep(5'b01000, 16'h6AA9);
        cond_sweep(5'b10101, 16'h6A56);

        // Reset asserted while in SAVE.
        req_done(1'b1, 1'b0);
        tick();
        write_psr(5'b10101);
        int_enter = 1'b1;
        tick();
        check("pre-reset busy", 16'(busy), 16'h1);
        check("pre-reset stack_empty", 16'(stack_empty), 16'h0);
        #2 reset = 1'b0;
        #1;
        int_enter = 1'b0;
        check("reset in save psr_out", 16'(psr_out), 16'h00);
        check("reset in save busy", 16'(busy), 16'h0);
        check("reset in save stack_empty", 16'(stack_empty), 16'h1);
        check("reset in save req_ack", 16'(req_ack), 16'h0);
        ack_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ack_seen = ack_seen | req_ack;
            if (i == 1) reset = 1'b1;
        end
        check("reset in save no ack", 16'(ack_seen), 16'h0);
        check("reset in save idle", 16'(busy), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
